pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8, meaning the maximum number of cycles imem_req waits for imem_ack before a fault.
REQ-002 SHALL size every word-wide port with `WORD (16) from fmt.v.
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port run, input, 1, which enables sequencing from IDLE.
REQ-006 SHALL have port halt_req, input, 1, which stops at the next instruction boundary.
REQ-007 SHALL have ports imem_req (output, 1), imem_ack (input, 1) and imem_rdata (input, `WORD), the instruction memory handshake.
REQ-008 SHALL have port instr, output, `WORD, the latched current instruction.
REQ-009 SHALL have ports exec_start (output, 1) and exec_done (input, 1), the execute handshake.
REQ-010 SHALL have ports br_taken (input, 1), br_abs (input, 1), br_target (input, `WORD) and br_offset (input, signed `WORD), the branch result valid with exec_done.
REQ-011 SHALL have ports pc_fetch, pc_wb_tr and pc_jump (outputs, 1 each), which drive PC_fetch, PC_wb_tr and jump of program_counter.
REQ-012 SHALL have ports jump_loc (output, `WORD) and jump_inc (output, signed `WORD), which drive program_counter.
REQ-013 SHALL have ports busy (output, 1), high when not in IDLE or FAULT, and fault (output, 1), the sticky timeout flag.

Function
REQ-014 SHALL implement the states IDLE, FETCH, IMEM, EXEC, UPDATE and FAULT.
REQ-015 SHALL go IDLE->FETCH on a clock edge with run=1 and halt_req=0, and SHALL otherwise stay in IDLE.
REQ-016 FETCH SHALL last exactly one cycle with pc_fetch=1 and then go to IMEM.
REQ-017 IMEM SHALL hold imem_req=1 until imem_ack=1, latch imem_rdata into instr on that edge, and go to EXEC.
REQ-018 IMEM SHALL count wait cycles from 0 on entry, and on TIMEOUT_CYC cycles without ack SHALL go to FAULT; an ack in the expiry cycle SHALL win.
REQ-019 EXEC SHALL pulse exec_start for only its first cycle, and SHALL sample exec_done from that cycle onward, including a same-cycle done.
REQ-020 On exec_done SHALL register br_taken, br_abs, br_target and br_offset, then go to UPDATE.
REQ-021 UPDATE SHALL last one cycle and assert exactly one strobe:
  - not taken: pc_wb_tr=1, jump_inc=1
  - taken, relative: pc_wb_tr=1, jump_inc=br_offset (two's complement; wraps modulo 2^16 in program_counter)
  - taken, absolute: pc_jump=1, jump_loc=br_target
REQ-022 pc_fetch SHALL never be high in the same cycle as pc_jump or pc_wb_tr.
REQ-023 After UPDATE SHALL go to IDLE if halt_req=1 or run=0, else to FETCH; run/halt_req changes mid-instruction SHALL be ignored until UPDATE.
REQ-024 FAULT SHALL hold fault=1 and deassert all strobes and requests until reset.
REQ-025 jump_loc and jump_inc SHALL be 0 in every cycle other than UPDATE.
REQ-026 Inputs imem_ack and exec_done arriving outside IMEM/EXEC SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, with instr, jump_loc and jump_inc at 0, all 1-bit outputs at 0, and counters at 0.
REQ-028 Reset asserted mid-instruction SHALL abort it, with no PC strobe issued afterwards until a new FETCH.

Configuration
REQ-029 With PC_SEQ_PERF_EN defined, SHALL add outputs cyc_count and instr_count (`WORD each), which count busy cycles and completed UPDATEs, wrap at 2^16, clear on reset, and freeze in FAULT.
REQ-030 Without PC_SEQ_PERF_EN, these ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-031 A bench SHALL cover: run=1, imem_ack 2 cycles after req, exec_done immediately, not taken -> pc_fetch, then pc_wb_tr with jump_inc=1 at cycle 5 after run; PC goes 0->1.
REQ-032 A bench SHALL cover: relative branch br_offset=-3 (0xFFFD) from PC=5 -> pc_wb_tr with jump_inc=0xFFFD; PC=2.
REQ-033 A bench SHALL cover: absolute branch br_target=0x0100 -> pc_jump=1, jump_loc=0x0100, pc_fetch=0 that cycle; next fetch location=0x0100.
REQ-034 A bench SHALL cover: imem_ack never, TIMEOUT_CYC=8 -> fault=1 eight cycles after imem_req rises; no strobes afterwards; rst_n clears it.
REQ-035 A bench SHALL cover: halt_req pulsed during EXEC -> instruction completes its UPDATE, then IDLE with busy=0.
REQ-036 A bench SHALL cover: rst_n low in EXEC -> all outputs 0 asynchronously; with PC_SEQ_PERF_EN, 3 instructions -> instr_count=3.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives a program_counter through fetch / execute / update.
// One instruction at a time goes IDLE -> FETCH -> IMEM -> EXEC -> UPDATE.
// If imem_ack does not arrive within TIMEOUT_CYC cycles, the sequencer
// enters FAULT and stays there until reset.
// Optional feature: define PC_SEQ_PERF_EN to add the cyc_count and
// instr_count performance counters.
// The word width comes from `WORD (fmt.v). It falls back to 16 when that
// header is not compiled ahead of this file.

`ifndef WORD
`define WORD 16
`endif

module pc_sequencer #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     halt_req,
    output logic                     imem_req,
    input  logic                     imem_ack,
    input  logic [`WORD-1:0]         imem_rdata,
    output logic [`WORD-1:0]         instr,
    output logic                     exec_start,
    input  logic                     exec_done,
    input  logic                     br_taken,
    input  logic                     br_abs,
    input  logic [`WORD-1:0]         br_target,
    input  logic signed [`WORD-1:0]  br_offset,
    output logic                     pc_fetch,
    output logic                     pc_wb_tr,
    output logic                     pc_jump,
    output logic [`WORD-1:0]         jump_loc,
    output logic signed [`WORD-1:0]  jump_inc,
    output logic                     busy,
    output logic                     fault
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [`WORD-1:0]         cyc_count,
    output logic [`WORD-1:0]         instr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_IMEM   = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // The wait counter only needs to reach TIMEOUT_CYC-1. Expiry is detected
    // on the last counted cycle, so the counter never has to hold TIMEOUT_CYC.
    localparam int            CW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t                    state_q, state_d;
    logic [CW-1:0]             wait_cnt_q, wait_cnt_d;
    logic [`WORD-1:0]          instr_q;
    logic                      br_taken_q, br_abs_q;
    logic [`WORD-1:0]          br_target_q;
    logic signed [`WORD-1:0]   br_offset_q;
    logic                      exec_seen_q;
    logic                      halt_pend_q;

    // State register and IMEM wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic. An ack in the expiry cycle is tested first, so it wins.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            S_IDLE:   if (run && !halt_req) state_d = S_FETCH;
            S_FETCH:  state_d = S_IMEM;
            S_IMEM: begin
                if (imem_ack) begin
                    state_d = S_EXEC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_EXEC:   if (exec_done) state_d = S_UPDATE;
            S_UPDATE: state_d = (halt_req || halt_pend_q || !run) ? S_IDLE : S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the instruction and branch result, and track the first
    // EXEC cycle. A halt request seen mid-instruction is held pending until
    // the UPDATE boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= '0;
            br_taken_q  <= 1'b0;
            br_abs_q    <= 1'b0;
            br_target_q <= '0;
            br_offset_q <= '0;
            exec_seen_q <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            if (state_q == S_IMEM && imem_ack) begin
                instr_q <= imem_rdata;
            end
            if (state_q == S_EXEC && exec_done) begin
                br_taken_q  <= br_taken;
                br_abs_q    <= br_abs;
                br_target_q <= br_target;
                br_offset_q <= br_offset;
            end
            exec_seen_q <= (state_q == S_EXEC);
            if (state_q == S_FETCH || state_q == S_IMEM || state_q == S_EXEC) begin
                halt_pend_q <= halt_pend_q | halt_req;
            end else begin
                halt_pend_q <= 1'b0;
            end
        end
    end

    // Outputs are decoded from state only. This keeps the strobes mutually
    // exclusive, and a reset clears them at once.
    always_comb begin
        imem_req   = (state_q == S_IMEM);
        pc_fetch   = (state_q == S_FETCH);
        exec_start = (state_q == S_EXEC) && !exec_seen_q;
        busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
        fault      = (state_q == S_FAULT);
        instr      = instr_q;
        pc_wb_tr   = 1'b0;
        pc_jump    = 1'b0;
        jump_loc   = '0;
        jump_inc   = '0;
        if (state_q == S_UPDATE) begin
            if (!br_taken_q) begin
                pc_wb_tr = 1'b1;
                jump_inc = `WORD'(1);
            end else if (!br_abs_q) begin
                pc_wb_tr = 1'b1;
                jump_inc = br_offset_q;
            end else begin
                pc_jump  = 1'b1;
                jump_loc = br_target_q;
            end
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [`WORD-1:0] cyc_count_q, instr_count_q;

    // Performance counters. They stop in IDLE and FAULT because busy is low there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_count_q   <= '0;
            instr_count_q <= '0;
        end else begin
            if (busy) cyc_count_q <= cyc_count_q + 1'b1;
            if (state_q == S_UPDATE) instr_count_q <= instr_count_q + 1'b1;
        end
    end

    assign cyc_count   = cyc_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with a small program_counter model.
// Inputs are driven on the falling edge and outputs are sampled there too.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, halt_req;
    logic        imem_req, imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        exec_start, exec_done;
    logic        br_taken, br_abs;
    logic [15:0] br_target;
    logic signed [15:0] br_offset;
    logic        pc_fetch, pc_wb_tr, pc_jump;
    logic [15:0] jump_loc;
    logic signed [15:0] jump_inc;
    logic        busy, fault;
`ifdef PC_SEQ_PERF_EN
    logic [15:0] cyc_count, instr_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference program counter, updated from the DUT strobes.
    logic [15:0] pc_model = 16'h0000;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_load)       pc_model <= pc_load_val;
        else if (pc_jump)  pc_model <= jump_loc;
        else if (pc_wb_tr) pc_model <= pc_model + jump_inc;
    end

    pc_sequencer #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .exec_start(exec_start), .exec_done(exec_done),
        .br_taken(br_taken), .br_abs(br_abs), .br_target(br_target), .br_offset(br_offset),
        .pc_fetch(pc_fetch), .pc_wb_tr(pc_wb_tr), .pc_jump(pc_jump),
        .jump_loc(jump_loc), .jump_inc(jump_inc), .busy(busy), .fault(fault)
`ifdef PC_SEQ_PERF_EN
        , .cyc_count(cyc_count), .instr_count(instr_count)
`endif
    );

    task automatic clear_inputs();
        run = 0; halt_req = 0; imem_ack = 0; imem_rdata = 16'h0;
        exec_done = 0; br_taken = 0; br_abs = 0; br_target = 16'h0; br_offset = 16'sh0;
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_load = 1; pc_load_val = v;
        @(negedge clk);
        pc_load = 0;
    endtask

    // Called on a falling edge while IDLE; returns on the falling edge in FETCH.
    task automatic start_run();
        run = 1;
        @(negedge clk);
    endtask

    // Called on a falling edge in FETCH; returns on the falling edge in UPDATE.
    task automatic to_update(input logic [15:0] rdata, input int ack_delay,
                             input logic taken, input logic absb,
                             input logic [15:0] tgt, input logic [15:0] off,
                             input logic keep_run, input logic halt_in_exec);
        run = keep_run;
        @(negedge clk);
        repeat (ack_delay - 1) @(negedge clk);
        imem_ack = 1; imem_rdata = rdata;
        @(negedge clk);
        imem_ack = 0;
        halt_req = halt_in_exec;
        exec_done = 1; br_taken = taken; br_abs = absb; br_target = tgt; br_offset = off;
        @(negedge clk);
        exec_done = 0; halt_req = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        pc_load = 1; pc_load_val = 16'h0;
        #1;
        checks++;
        if ({imem_req, exec_start, pc_fetch, pc_wb_tr, pc_jump, busy, fault, instr, jump_loc, jump_inc} !== 55'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {imem_req, exec_start, pc_fetch, pc_wb_tr, pc_jump, busy, fault, instr, jump_loc, jump_inc});
        end
        repeat (2) @(negedge clk);
        rst_n = 1; pc_load = 0;
        // Requests outside IMEM/EXEC, and run with halt_req, must not start anything.
        imem_ack = 1; exec_done = 1; imem_rdata = 16'hDEAD; run = 1; halt_req = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || instr !== 16'h0 || pc_wb_tr !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b instr=%h wb=%b want busy=0 instr=0000 wb=0", busy, instr, pc_wb_tr);
        end
        clear_inputs();
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        run = 1;
        @(negedge clk);                          // cycle 1: FETCH
        checks++;
        if (pc_fetch !== 1'b1 || busy !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_fetch got fetch=%b busy=%b req=%b want 1 1 0", pc_fetch, busy, imem_req);
        end
        run = 0;
        @(negedge clk);                          // cycle 2: IMEM, first wait
        checks++;
        if (imem_req !== 1'b1 || pc_fetch !== 1'b0) begin
            errors++;
            $display("FAIL basic_req got req=%b fetch=%b want 1 0", imem_req, pc_fetch);
        end
        @(negedge clk);                          // cycle 3: IMEM, ack
        imem_ack = 1; imem_rdata = 16'h1234;
        @(negedge clk);                          // cycle 4: EXEC
        imem_ack = 0;
        checks++;
        if (exec_start !== 1'b1 || instr !== 16'h1234 || jump_inc !== 16'sh0) begin
            errors++;
            $display("FAIL basic_exec got start=%b instr=%h inc=%h want 1 1234 0000", exec_start, instr, jump_inc);
        end
        exec_done = 1; br_taken = 0;
        @(negedge clk);                          // cycle 5: UPDATE
        exec_done = 0;
        checks++;
        if (pc_wb_tr !== 1'b1 || jump_inc !== 16'sh0001 || pc_jump !== 1'b0 || pc_fetch !== 1'b0) begin
            errors++;
            $display("FAIL basic_update got wb=%b inc=%h jump=%b fetch=%b want 1 0001 0 0",
                     pc_wb_tr, jump_inc, pc_jump, pc_fetch);
        end
        @(negedge clk);
        checks++;
        if (pc_model !== 16'h0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pc got pc=%h busy=%b want 0001 0", pc_model, busy);
        end
        $display("test_basic pc=%h", pc_model);
    endtask

    task automatic test_rel_branch();
        set_pc(16'h0005);
        start_run();
        to_update(16'hA001, 1, 1'b1, 1'b0, 16'h0, 16'hFFFD, 1'b0, 1'b0);
        checks++;
        if (pc_wb_tr !== 1'b1 || jump_inc !== 16'shFFFD || pc_jump !== 1'b0 || jump_loc !== 16'h0) begin
            errors++;
            $display("FAIL rel_update got wb=%b inc=%h jump=%b loc=%h want 1 fffd 0 0000",
                     pc_wb_tr, jump_inc, pc_jump, jump_loc);
        end
        @(negedge clk);
        checks++;
        if (pc_model !== 16'h0002) begin
            errors++;
            $display("FAIL rel_pc got=%h want=0002", pc_model);
        end
        $display("test_rel_branch pc=%h", pc_model);
    endtask

    task automatic test_abs_branch();
        set_pc(16'h0040);
        start_run();
        to_update(16'hA002, 1, 1'b1, 1'b1, 16'h0100, 16'h0007, 1'b1, 1'b0);
        checks++;
        if (pc_jump !== 1'b1 || jump_loc !== 16'h0100 || pc_fetch !== 1'b0 || pc_wb_tr !== 1'b0 || jump_inc !== 16'sh0) begin
            errors++;
            $display("FAIL abs_update got jump=%b loc=%h fetch=%b wb=%b inc=%h want 1 0100 0 0 0000",
                     pc_jump, jump_loc, pc_fetch, pc_wb_tr, jump_inc);
        end
        @(negedge clk);                          // next FETCH
        checks++;
        if (pc_fetch !== 1'b1 || pc_model !== 16'h0100 || jump_loc !== 16'h0 || pc_jump !== 1'b0) begin
            errors++;
            $display("FAIL abs_next_fetch got fetch=%b pc=%h loc=%h jump=%b want 1 0100 0000 0",
                     pc_fetch, pc_model, jump_loc, pc_jump);
        end
        to_update(16'hA003, 1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (pc_model !== 16'h0101 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abs_follow got pc=%h busy=%b want 0101 0", pc_model, busy);
        end
        $display("test_abs_branch pc=%h", pc_model);
    endtask

    task automatic test_timeout();
        logic bad;
        // An ack on the last allowed wait cycle still proceeds.
        start_run();
        to_update(16'hB00B, 8, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0 || pc_wb_tr !== 1'b1 || instr !== 16'hB00B) begin
            errors++;
            $display("FAIL ack_at_expiry got fault=%b wb=%b instr=%h want 0 1 b00b", fault, pc_wb_tr, instr);
        end
        @(negedge clk);
        // No ack at all: the sequencer faults 8 cycles after imem_req rises.
        start_run();
        run = 0;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (imem_req !== 1'b1 || fault !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL timeout_wait got early fault or dropped req want 8 clean wait cycles");
        end
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault got fault=%b req=%b busy=%b want 1 0 0", fault, imem_req, busy);
        end
        imem_ack = 1; exec_done = 1; run = 1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if ({pc_fetch, pc_wb_tr, pc_jump, imem_req, exec_start} !== 5'b0 || fault !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL fault_quiet got strobe or lost fault want all strobes 0 fault=1");
        end
        clear_inputs();
        rst_n = 0;
        #1;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_reset got=%b want=0", fault);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        $display("test_timeout done");
    endtask

    task automatic test_halt();
        start_run();
        to_update(16'hC0DE, 1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        checks++;
        if (pc_wb_tr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL halt_update got wb=%b busy=%b want 1 1", pc_wb_tr, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pc_fetch !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle got busy=%b fetch=%b want 0 0", busy, pc_fetch);
        end
        run = 0;
        @(negedge clk);
        $display("test_halt done");
    endtask

    task automatic test_reset_in_exec();
        logic bad;
        start_run();
        run = 0;
        @(negedge clk);
        imem_ack = 1; imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_ack = 0;
        checks++;
        if (exec_start !== 1'b1 || instr !== 16'hBEEF) begin
            errors++;
            $display("FAIL rexec_pre got start=%b instr=%h want 1 beef", exec_start, instr);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({imem_req, exec_start, pc_fetch, pc_wb_tr, pc_jump, busy, fault, instr, jump_loc, jump_inc} !== 55'h0) begin
            errors++;
            $display("FAIL rexec_async got=%h want=0",
                     {imem_req, exec_start, pc_fetch, pc_wb_tr, pc_jump, busy, fault, instr, jump_loc, jump_inc});
        end
        exec_done = 1; br_taken = 1; br_abs = 1; br_target = 16'h0333;
        @(negedge clk);
        rst_n = 1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if ({pc_wb_tr, pc_jump, pc_fetch, busy} !== 4'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rexec_after got a strobe after abort want none");
        end
        clear_inputs();
        $display("test_reset_in_exec done");
    endtask

    task automatic test_back_to_back();
        set_pc(16'h0010);
        start_run();
        to_update(16'h0001, 1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (pc_fetch !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fetch2 got=%b want=1", pc_fetch);
        end
        to_update(16'h0002, 1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        to_update(16'h0003, 1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (pc_model !== 16'h0013 || busy !== 1'b0 || instr !== 16'h0003) begin
            errors++;
            $display("FAIL b2b_pc got pc=%h busy=%b instr=%h want 0013 0 0003", pc_model, busy, instr);
        end
`ifdef PC_SEQ_PERF_EN
        checks++;
        if (instr_count !== 16'd3) begin
            errors++;
            $display("FAIL perf_instr got=%0d want=3", instr_count);
        end
        checks++;
        if (cyc_count !== 16'd12) begin
            errors++;
            $display("FAIL perf_cyc got=%0d want=12", cyc_count);
        end
`endif
        $display("test_back_to_back pc=%h", pc_model);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rel_branch();
        test_abs_branch();
        test_timeout();
        test_halt();
        test_reset_in_exec();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
